// File: rtl/snes_pkg.sv
// +------------------------------------------------------------------+
// | Module : snes_pkg                                                |
// | Desc   : Shared SNES button indices, event layout and helpers.   |
// |          SNES_EVT_TIMESTAMP_EN widens events with a frame stamp.  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package snes_pkg;

  localparam int NUM_BTNS = 12;

  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int RIGHT  = 6;
  localparam int LEFT   = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_IDX_LSB   = 0;
  localparam int EVT_IDX_W     = 4;
  localparam int EVT_W         = 8;
  localparam int TS_W          = 16;

`ifdef SNES_EVT_TIMESTAMP_EN
  localparam int EVT_DATA_W = TS_W + EVT_W;
`else
  localparam int EVT_DATA_W = EVT_W;
`endif

  typedef struct packed {
    logic                 press;
    logic [2:0]           rsvd;
    logic [EVT_IDX_W-1:0] idx;
  } evt_t;

  function automatic evt_t make_evt(input logic press, input logic [EVT_IDX_W-1:0] idx);
    evt_t e;
    e.press = press;
    e.rsvd  = 3'b000;
    e.idx   = idx;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snes_evt_fifo.sv
// +------------------------------------------------------------------+
// | Module : snes_evt_fifo                                           |
// | Desc   : Synchronous first-word-fall-through event FIFO.         |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module snes_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (c_AW+1)'(DEPTH));
  assign w_pop_ok  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push_ok = push & (~full | w_pop_ok);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/snes_btn_event_queue.sv
// +------------------------------------------------------------------+
// | Module : snes_btn_event_queue                                    |
// | Desc   : Debounces SNES button frames and queues press/release   |
// |          events; SNES_EVT_TIMESTAMP_EN adds a 16-bit frame stamp. |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module snes_btn_event_queue #(
  parameter int NUM_BTNS       = 12,
  parameter int DEBOUNCE_POLLS = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                              clk_25M,
  input  logic                              rst,
  input  logic [NUM_BTNS-1:0]               btn_in,
  input  logic                              btn_valid,
  input  logic                              evt_rd,
  input  logic                              ovf_clr,
  output logic [NUM_BTNS-1:0]               btn_stable,
  output logic [snes_pkg::EVT_DATA_W-1:0]   evt_data,
  output logic                              evt_valid,
  output logic [$clog2(FIFO_DEPTH):0]       evt_count,
  output logic                              overflow
);

  import snes_pkg::*;

  localparam int         c_IDX_W   = EVT_IDX_W;
  localparam logic [2:0] c_DEB     = 3'(DEBOUNCE_POLLS);
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_SCAN = 1'b1;

  logic [NUM_BTNS-1:0]   w_norm;
  logic [NUM_BTNS-1:0]   w_stable;
  logic [NUM_BTNS-1:0]   w_flip;
  logic [NUM_BTNS-1:0]   w_clr;
  logic [NUM_BTNS-1:0]   w_pend_nxt;
  logic [NUM_BTNS-1:0]   r_pend;
  logic [c_IDX_W-1:0]    w_idx;
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic                  r_ovf;
  evt_t                  w_evt;
  logic [EVT_DATA_W-1:0] w_din;

  assign w_norm = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      logic [2:0] r_cnt;
      logic       r_bit;
      logic       w_diff;
      logic       w_hit;

      assign w_diff       = w_norm[gi] ^ r_bit;
      assign w_hit        = btn_valid & w_diff & ((r_cnt + 3'd1) == c_DEB);
      assign w_flip[gi]   = w_hit;
      assign w_stable[gi] = r_bit;

      always_ff @(posedge clk_25M) begin
        if (rst) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (btn_valid) begin
          if (!w_diff || w_hit) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
          if (w_hit) begin
            r_bit <= w_norm[gi];
          end
        end
      end
    end
  endgenerate

  // Lowest pending index wins: the descending loop leaves the smallest hit last.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_idx = c_IDX_W'(i);
      end
    end
  end

  // A same-cycle flip re-arms a bit the scanner is clearing.
  assign w_clr      = w_push ? (NUM_BTNS'(1) << w_idx) : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_flip;

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (r_pend != '0) w_state_nxt = c_ST_SCAN;
      c_ST_SCAN: if (w_pend_nxt == '0) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    if (r_state == c_ST_SCAN) begin
      w_push = 1'b1;
    end
  end

  assign w_evt = make_evt(w_stable[w_idx], w_idx);

`ifdef SNES_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_frame;

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_frame <= '0;
    end else if (btn_valid) begin
      r_frame <= r_frame + 1'b1;
    end
  end

  assign w_din = {r_frame, w_evt};
`else
  assign w_din = w_evt;
`endif

  assign w_pop  = evt_rd & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  snes_evt_fifo #(
    .WIDTH (EVT_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_25M),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (evt_rd),
    .dout  (evt_data),
    .full  (w_full),
    .empty (w_empty),
    .count (evt_count)
  );

  assign btn_stable = w_stable;
  assign evt_valid  = ~w_empty;
  assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: doc/snes_btn_event_queue.md
Name: snes_btn_event_queue

Overview:
- Downstream consumer of the SNES controller stage's 12-bit button word.
- Debounces each button across successive poll frames and keeps a stable button image.
- Turns every stable press/release into a one-byte event in a small FWFT FIFO that software or a game-logic block drains at its own pace.
- Runs in the 25 MHz controller domain.

Parameters:
- NUM_BTNS, 12, buttons per frame; btn_in bit i = button index i.
- DEBOUNCE_POLLS, 2, consecutive disagreeing polls (1..7) needed before the stable value flips.
- FIFO_DEPTH, 16, event FIFO entries; power of two, 4..64.
- BTN_ACTIVE_LOW, 0, if 1, btn_in is inverted at the input so that internal 1 = pressed.

Ports:
- clk_25M  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_in  in  NUM_BTNS  button word from the controller stage
- btn_valid  in  1  one-cycle strobe: btn_in holds a completed poll frame
- evt_rd  in  1  pop strobe; ignored when evt_valid=0
- ovf_clr  in  1  clears the overflow flag
- btn_stable  out  NUM_BTNS  debounced image, 1 = pressed
- evt_data  out  8  head event: [7] 1 = press / 0 = release, [6:4] 0, [3:0] button index
- evt_valid  out  1  FIFO non-empty
- evt_count  out  clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset: btn_stable=0, all debounce counters=0, pending mask=0, FIFO empty, evt_valid=0, evt_count=0, overflow=0, evt_data=0, FSM=IDLE. Reset mid-scan discards pending and queued events.
- Debounce (only on cycles with btn_valid=1), per button i, with s = normalised btn_in[i]:
  - If s == btn_stable[i]: cnt[i] := 0.
  - Otherwise cnt[i] := cnt[i]+1.
  - When cnt[i]+1 == DEBOUNCE_POLLS: btn_stable[i] := s, cnt[i] := 0, pending[i] := 1, all in the same cycle.
  - cnt is 3 bits and never exceeds DEBOUNCE_POLLS-1.
  - With DEBOUNCE_POLLS=1, btn_stable follows the sampled value on the strobe cycle.
- Scan FSM:
  - IDLE -> SCAN when pending != 0.
  - In SCAN, one event per cycle, lowest pending index first. Push {btn_stable[idx], 3'b0, idx} and clear pending[idx].
  - SCAN -> IDLE when the pending mask (after this cycle's clear and set) is 0.
  - Latency: btn_valid edge causing a flip -> pending set at edge+1 -> first push at edge+2 -> evt_valid at edge+3.
- Simultaneous flip and clear: a debounce flip on the same cycle the scanner clears that bit leaves pending[idx]=1. The set wins, and the later event reports the then-current stable value.
- Double flip before the scan: if a button flips twice before its event is pushed, one event carrying the final stable value is emitted. This is accepted loss.
- FIFO: first-word-fall-through.
  - Push succeeds if not full, or if full with a valid pop in the same cycle.
  - Push while full with no pop: the event is dropped, pending is still cleared, and overflow := 1.
  - Pop while empty: no effect.
  - Push and pop together while empty: the entry appears next cycle and evt_count=1.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set by a drop, cleared by ovf_clr. If both happen in the same cycle, set wins.
- evt_count and evt_valid update the cycle after a push or pop.

Optional Feature:
- Macro SNES_EVT_TIMESTAMP_EN.
- When defined:
  - Adds a 16-bit frame counter, reset to 0, incremented on every btn_valid and wrapping at 0xFFFF.
  - evt_data widens to 24 bits; [23:8] = counter value at push time, [7:0] unchanged.
  - FIFO width grows to match.
- When undefined: no counter, and evt_data is 8 bits.

Decomposition:
- Package snes_pkg:
  - NUM_BTNS=12.
  - Button index constants B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, RIGHT=6, LEFT=7, A=8, X=9, L=10, R=11.
  - Event field positions EVT_PRESS_BIT=7, EVT_IDX_LSB=0, EVT_IDX_W=4.
  - Event typedef.
- Sub-module snes_evt_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- Debounce and scan logic stay in the top level.

Test Plan:
- Reset, then btn_valid pulses with btn_in=0 -> btn_stable=0, evt_valid=0, evt_count=0 throughout.
- btn_in=12'b0101_1100_1001 held for 2 polls -> btn_stable=0x5C9 after the 2nd strobe; 6 events pushed in index order 0,3,6,7,8,10, each with bit7=1 (0x80, 0x83, 0x86, 0x87, 0x88, 0x8A); evt_count=6.
- Glitch: START=1 for 1 poll then 0 -> btn_stable[3] stays 0 and no event. START=1 for 2 polls then 0 for 2 polls -> events 0x83 then 0x03.
- Overflow: 12 press + 12 release events with no reads -> FIFO holds the first 16 events, overflow=1. Pulse ovf_clr -> overflow=0. Pop 16 times -> evt_valid=0.
- Full FIFO with evt_rd held during a new push -> no drop, evt_count stays 16, overflow stays 0.
- rst asserted during SCAN with 5 pending events -> next cycle evt_valid=0, evt_count=0, btn_stable=0. With SNES_EVT_TIMESTAMP_EN, the first post-reset event shows [23:8] = number of strobes since reset.
